// File: rtl/io_port_pkg.sv
// Shared defaults and encodings for the I/O port unit.
// Interrupt state encoding is used only when IO_PORT_INTR_EN is defined.
package io_port_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int IN_DEPTH_DEF    = 4;
    localparam int INTR_CYCLES_DEF = 2;
    localparam int PTR_W_DEF       = $clog2(IN_DEPTH_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } intr_state_t;

endpackage

// File: rtl/io_in_fifo.sv
// Input FIFO: registered storage, combinational head read.
// The head reads as zero while the FIFO is empty.
module io_in_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = IN_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd,
    output logic [DATA_W-1:0] head,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign wr_ready = (count < CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = wr_valid && wr_ready;
    assign do_pop   = rd && !empty;
    assign head     = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until the count covers them
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// Peripheral end of the 16-bit IN/OUT port interface.
// Optional arrival interrupt built only with IO_PORT_INTR_EN.
module io_port_unit
    import io_port_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IN_DEPTH    = IN_DEPTH_DEF,
    parameter int INTR_CYCLES = INTR_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] in_port,
    input  logic              in_rd,
    input  logic [DATA_W-1:0] out_port,
    input  logic              out_wr,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic              intr,
    output logic              in_udf,
    output logic              out_ovf,
    input  logic              clr_flags
);

    logic fifo_empty;
    logic udf_evt;
    logic ovf_evt;
    logic out_load;

    io_in_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (ext_in_data),
        .wr_valid (ext_in_valid),
        .wr_ready (ext_in_ready),
        .rd       (in_rd),
        .head     (in_port),
        .empty    (fifo_empty)
    );

    assign udf_evt  = in_rd && fifo_empty;
    assign out_load = out_wr && (!ext_out_valid || ext_out_ready);
    assign ovf_evt  = out_wr && ext_out_valid && !ext_out_ready;

    // Output holding register; a write while draining replaces the word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_out_data  <= '0;
            ext_out_valid <= 1'b0;
        end else if (out_load) begin
            ext_out_data  <= out_port;
            ext_out_valid <= 1'b1;
        end else if (ext_out_valid && ext_out_ready) begin
            ext_out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_udf  <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            in_udf  <= udf_evt || (in_udf && !clr_flags);
            out_ovf <= ovf_evt || (out_ovf && !clr_flags);
        end
    end

`ifdef IO_PORT_INTR_EN

    localparam int CNT_W = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;

    intr_state_t      state;
    intr_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             trigger;

    assign trigger = ext_in_valid && ext_in_ready && fifo_empty;

    // State, counter and registered interrupt output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            intr  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            intr  <= (state_next == PULSE);
        end
    end

    // Next state: fire on empty->non-empty, hold for INTR_CYCLES cycles
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = PULSE;
                    cnt_next   = CNT_W'(INTR_CYCLES - 1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

`else

    assign intr = 1'b0;

`endif

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit with an in_port scoreboard.
// Interrupt expectations follow IO_PORT_INTR_EN.
module tb_io_port_unit;

    localparam int W = 16;

`ifdef IO_PORT_INTR_EN
    localparam logic IE = 1'b1;
`else
    localparam logic IE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] ext_in_data;
    logic         ext_in_valid;
    logic         ext_in_ready;
    logic [W-1:0] in_port;
    logic         in_rd;
    logic [W-1:0] out_port;
    logic         out_wr;
    logic [W-1:0] ext_out_data;
    logic         ext_out_valid;
    logic         ext_out_ready;
    logic         intr;
    logic         in_udf;
    logic         out_ovf;
    logic         clr_flags;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb [$];

    io_port_unit dut (
        .clk           (clk),
        .reset         (reset),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .in_port       (in_port),
        .in_rd         (in_rd),
        .out_port      (out_port),
        .out_wr        (out_wr),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .intr          (intr),
        .in_udf        (in_udf),
        .out_ovf       (out_ovf),
        .clr_flags     (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare head against scoreboard, then strobe in_rd for one cycle
    task automatic pop_chk(input string tag);
        logic [W-1:0] e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_sb expected=entry", tag);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk(tag, 32'(in_port), 32'(e));
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        ext_in_data  = d;
        ext_in_valid = 1'b1;
        sb.push_back(d);
        tick();
        ext_in_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        ext_in_data   = '0;
        ext_in_valid  = 1'b0;
        in_rd         = 1'b0;
        out_port      = '0;
        out_wr        = 1'b0;
        ext_out_ready = 1'b0;
        clr_flags     = 1'b0;
        tick();
        chk("rst_in_port", 32'(in_port), 32'h0);
        chk("rst_in_ready", 32'(ext_in_ready), 32'h1);
        chk("rst_out_valid", 32'(ext_out_valid), 32'h0);
        chk("rst_out_data", 32'(ext_out_data), 32'h0);
        chk("rst_intr", 32'(intr), 32'h0);
        chk("rst_flags", 32'({in_udf, out_ovf}), 32'h0);
        reset = 1'b1;
        tick();

        // single push and interrupt pulse
        push(16'hA5A5);
        chk("intr_c1", 32'(intr), 32'(IE));
        chk("a5_head", 32'(in_port), 32'hA5A5);
        tick();
        chk("intr_c2", 32'(intr), 32'(IE));
        tick();
        chk("intr_c3", 32'(intr), 32'h0);
        pop_chk("a5_pop");
        chk("a5_empty", 32'(in_port), 32'h0);

        // fill to full, hold off fifth word, drain
        for (int i = 1; i <= 4; i++) begin
            push(W'(i));
        end
        chk("full_ready", 32'(ext_in_ready), 32'h0);
        ext_in_data  = 16'h0005;
        ext_in_valid = 1'b1;
        tick();
        ext_in_valid = 1'b0;
        chk("full_hold", 32'(ext_in_ready), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            pop_chk("drain");
        end
        chk("drain_zero", 32'(in_port), 32'h0);
        chk("drain_ready", 32'(ext_in_ready), 32'h1);
        chk("drain_udf", 32'(in_udf), 32'h0);

        // simultaneous push and pop with two entries
        push(16'h0011);
        push(16'h0022);
        tick();
        tick();
        tick();
        chk("pp_pre_intr", 32'(intr), 32'h0);
        ext_in_data  = 16'h0007;
        ext_in_valid = 1'b1;
        sb.push_back(16'h0007);
        pop_chk("pp_pop");
        ext_in_valid = 1'b0;
        chk("pp_intr", 32'(intr), 32'h0);
        chk("pp_ready", 32'(ext_in_ready), 32'h1);
        pop_chk("pp_d1");
        pop_chk("pp_d2");
        chk("pp_zero", 32'(in_port), 32'h0);

        // underflow and flag clear priority
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
        chk("udf_set", 32'(in_udf), 32'h1);
        chk("udf_port", 32'(in_port), 32'h0);
        clr_flags = 1'b1;
        tick();
        chk("udf_clr", 32'(in_udf), 32'h0);
        in_rd = 1'b1;
        tick();
        in_rd     = 1'b0;
        clr_flags = 1'b0;
        chk("udf_win", 32'(in_udf), 32'h1);

        // underflow with simultaneous push still stores the word
        ext_in_data  = 16'hBEEF;
        ext_in_valid = 1'b1;
        in_rd        = 1'b1;
        sb.push_back(16'hBEEF);
        tick();
        ext_in_valid = 1'b0;
        in_rd        = 1'b0;
        chk("udf_push_intr", 32'(intr), 32'(IE));
        pop_chk("udf_push");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // output register
        out_port = 16'h1234;
        out_wr   = 1'b1;
        tick();
        chk("out_valid", 32'(ext_out_valid), 32'h1);
        chk("out_data", 32'(ext_out_data), 32'h1234);
        out_port = 16'h5678;
        tick();
        out_wr = 1'b0;
        chk("ovf_data", 32'(ext_out_data), 32'h1234);
        chk("ovf_flag", 32'(out_ovf), 32'h1);
        ext_out_ready = 1'b1;
        tick();
        ext_out_ready = 1'b0;
        chk("out_drop", 32'(ext_out_valid), 32'h0);
        chk("out_hold", 32'(ext_out_data), 32'h1234);
        clr_flags = 1'b1;
        out_port  = 16'h9ABC;
        out_wr    = 1'b1;
        tick();
        clr_flags     = 1'b0;
        out_port      = 16'hDEF0;
        ext_out_ready = 1'b1;
        tick();
        out_wr        = 1'b0;
        ext_out_ready = 1'b0;
        chk("wr_rdy_valid", 32'(ext_out_valid), 32'h1);
        chk("wr_rdy_data", 32'(ext_out_data), 32'hDEF0);
        chk("wr_rdy_ovf", 32'(out_ovf), 32'h0);

        // async reset during pulse
        push(16'h00C3);
        chk("ar_intr_pre", 32'(intr), 32'(IE));
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("ar_intr", 32'(intr), 32'h0);
        chk("ar_port", 32'(in_port), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_empty", 32'(in_port), 32'h0);
        chk("ar_ready", 32'(ext_in_ready), 32'h1);
        chk("ar_intr_post", 32'(intr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
